// File: rtl/deadlock_monitor_param.sv
// Dataflow deadlock monitor: flags a stable all-processes-stopped condition that involves a real block.
// Optional snapshot of blocked processes is built when DEADLOCK_MONITOR_SNAPSHOT_EN is defined.
module deadlock_monitor_param #(
    parameter int unsigned                N_PROC        = 8,
    parameter int unsigned                N_AXIS        = 2,
    parameter logic [N_PROC*N_AXIS-1:0]   AXIS_MAP      = '0,
    parameter int unsigned                STABLE_CYCLES = 4,
    parameter int unsigned                CNT_W         = 16,
    parameter int unsigned                MODE          = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic [N_AXIS-1:0] axis_block_sigs,
    input  logic [N_PROC-1:0] inst_idle_sigs,
    input  logic [N_PROC-1:0] inst_block_sigs,
    output logic              block,
    output logic              block_sticky,
    output logic [CNT_W-1:0]  stall_count,
    output logic [N_PROC-1:0] block_proc_vec
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] STABLE  = CNT_W'(STABLE_CYCLES);
    localparam logic             CHAN_OK = (MODE != 0);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_BLOCKED = 2'd2
    } state_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt_n;
    logic [CNT_W-1:0]  cnt_inc;
    logic [N_PROC-1:0] axis_blk;
    logic [N_PROC-1:0] stop;
    logic              all_stop;
    logic              cand;

    // Fold each stream source onto the processes that own it
    always_comb begin
        axis_blk = '0;
        for (int p = 0; p < int'(N_PROC); p++) begin
            for (int a = 0; a < int'(N_AXIS); a++) begin
                axis_blk[p] = axis_blk[p] | (AXIS_MAP[p*int'(N_AXIS)+a] & axis_block_sigs[a]);
            end
        end
    end

    // An all-idle design is finished, not deadlocked: a block must be present
    assign stop     = inst_idle_sigs | inst_block_sigs | axis_blk;
    assign all_stop = &stop;
    assign cand     = all_stop & ((|axis_blk) | (CHAN_OK & (|inst_block_sigs)));
    assign cnt_inc  = (stall_count == CNT_MAX) ? stall_count : stall_count + CNT_ONE;

    always_comb begin
        state_n = state;
        cnt_n   = stall_count;
        case (state)
            S_IDLE: begin
                if (cand) begin
                    cnt_n   = CNT_ONE;
                    state_n = (STABLE_CYCLES == 1) ? S_BLOCKED : S_ARMED;
                end else begin
                    cnt_n   = '0;
                end
            end
            S_ARMED: begin
                if (cand) begin
                    cnt_n = cnt_inc;
                    if (cnt_inc >= STABLE) begin
                        state_n = S_BLOCKED;
                    end
                end else begin
                    cnt_n   = '0;
                    state_n = S_IDLE;
                end
            end
            S_BLOCKED: begin
                if (cand) begin
                    cnt_n = cnt_inc;
                end else begin
                    cnt_n   = '0;
                    state_n = S_IDLE;
                end
            end
            default: begin
                cnt_n   = '0;
                state_n = S_IDLE;
            end
        endcase
        if (clear) begin
            cnt_n   = '0;
            state_n = S_IDLE;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            stall_count  <= '0;
            block        <= 1'b0;
            block_sticky <= 1'b0;
        end else begin
            state        <= state_n;
            stall_count  <= cnt_n;
            block        <= (state_n == S_BLOCKED);
            block_sticky <= !clear && (block_sticky || (state_n == S_BLOCKED));
        end
    end

`ifdef DEADLOCK_MONITOR_SNAPSHOT_EN
    logic [N_PROC-1:0] snap_q;
    logic              enter_blk;

    // Capture the culprits only on entry to BLOCKED
    assign enter_blk = (state_n == S_BLOCKED) && (state != S_BLOCKED);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            snap_q <= '0;
        end else if (clear) begin
            snap_q <= '0;
        end else if (enter_blk) begin
            snap_q <= inst_block_sigs | axis_blk;
        end
    end

    assign block_proc_vec = snap_q;
`else
    assign block_proc_vec = '0;
`endif

endmodule

// File: tb/tb_deadlock_monitor_param.sv
// Directed bench for deadlock_monitor_param: MODE 0 and MODE 1 monitors plus a single-cycle,
// narrow-counter variant, all driven from shared stimulus.
module tb_deadlock_monitor_param;

    localparam logic [15:0] MAP = 16'h8001;   // a0 -> p0, a1 -> p7
`ifdef DEADLOCK_MONITOR_SNAPSHOT_EN
    localparam logic [7:0] SNAP_EXP = 8'h81;
`else
    localparam logic [7:0] SNAP_EXP = 8'h00;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       clear = 1'b0;
    logic [1:0] axis_block_sigs = '0;
    logic [7:0] inst_idle_sigs  = 8'hFF;
    logic [7:0] inst_block_sigs = '0;

    logic        blk0, stk0;
    logic [15:0] cnt0;
    logic [7:0]  vec0;
    logic        blk1, stk1;
    logic [15:0] cnt1;
    logic [7:0]  vec1;
    logic        blks, stks;
    logic [2:0]  cnts;
    logic [7:0]  vecs;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    deadlock_monitor_param #(.N_PROC(8), .N_AXIS(2), .AXIS_MAP(MAP), .STABLE_CYCLES(4),
                             .CNT_W(16), .MODE(0)) u_m0 (
        .clock(clock), .reset(reset), .clear(clear), .axis_block_sigs(axis_block_sigs),
        .inst_idle_sigs(inst_idle_sigs), .inst_block_sigs(inst_block_sigs),
        .block(blk0), .block_sticky(stk0), .stall_count(cnt0), .block_proc_vec(vec0));

    deadlock_monitor_param #(.N_PROC(8), .N_AXIS(2), .AXIS_MAP(MAP), .STABLE_CYCLES(4),
                             .CNT_W(16), .MODE(1)) u_m1 (
        .clock(clock), .reset(reset), .clear(clear), .axis_block_sigs(axis_block_sigs),
        .inst_idle_sigs(inst_idle_sigs), .inst_block_sigs(inst_block_sigs),
        .block(blk1), .block_sticky(stk1), .stall_count(cnt1), .block_proc_vec(vec1));

    deadlock_monitor_param #(.N_PROC(8), .N_AXIS(2), .AXIS_MAP(MAP), .STABLE_CYCLES(1),
                             .CNT_W(3), .MODE(0)) u_s1 (
        .clock(clock), .reset(reset), .clear(clear), .axis_block_sigs(axis_block_sigs),
        .inst_idle_sigs(inst_idle_sigs), .inst_block_sigs(inst_block_sigs),
        .block(blks), .block_sticky(stks), .stall_count(cnts), .block_proc_vec(vecs));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic set_cand();
        inst_idle_sigs  = 8'h7E;
        inst_block_sigs = 8'h00;
        axis_block_sigs = 2'b11;
    endtask

    task automatic set_all_idle();
        inst_idle_sigs  = 8'hFF;
        inst_block_sigs = 8'h00;
        axis_block_sigs = 2'b00;
    endtask

    initial begin
        #12;
        check("rst_block",  32'(blk0), 32'd0);
        check("rst_sticky", 32'(stk0), 32'd0);
        check("rst_count",  32'(cnt0), 32'd0);
        check("rst_vec",    32'(vec0), 32'd0);
        reset = 1'b1;

        // all idle never detects, in either mode
        tick(6);
        check("idle_block0", 32'(blk0), 32'd0);
        check("idle_count0", 32'(cnt0), 32'd0);
        check("idle_block1", 32'(blk1), 32'd0);
        check("idle_count1", 32'(cnt1), 32'd0);

        // axis-driven deadlock, 4-cycle latency; single-cycle variant fires at once
        set_cand();
        tick(1);
        check("b_count1",   32'(cnt0), 32'd1);
        check("b_block1",   32'(blk0), 32'd0);
        check("s1_block",   32'(blks), 32'd1);
        check("s1_sticky",  32'(stks), 32'd1);
        tick(2);
        check("b_count3",   32'(cnt0), 32'd3);
        check("b_block3",   32'(blk0), 32'd0);
        tick(1);
        check("b_block4",   32'(blk0), 32'd1);
        check("b_count4",   32'(cnt0), 32'd4);
        check("b_sticky4",  32'(stk0), 32'd1);
        check("b_vec",      32'(vec0), 32'(SNAP_EXP));
        check("b_m1_block", 32'(blk1), 32'd1);
        tick(5);
        check("b_count9",   32'(cnt0), 32'd9);
        check("b_block9",   32'(blk0), 32'd1);
        check("s1_sat",     32'(cnts), 32'd7);

        // release: block drops, sticky holds
        set_all_idle();
        tick(1);
        check("rel_block",  32'(blk0), 32'd0);
        check("rel_count",  32'(cnt0), 32'd0);
        check("rel_sticky", 32'(stk0), 32'd1);

        // interrupted stall restarts the count
        set_cand();
        tick(3);
        check("c_count3",   32'(cnt0), 32'd3);
        inst_idle_sigs = 8'h76;
        tick(1);
        check("c_break_cnt", 32'(cnt0), 32'd0);
        check("c_break_blk", 32'(blk0), 32'd0);
        set_cand();
        tick(3);
        check("c_count3b",  32'(cnt0), 32'd3);
        check("c_block3b",  32'(blk0), 32'd0);
        tick(1);
        check("c_block4",   32'(blk0), 32'd1);

        // clear beats a live candidate, then detection repeats
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        check("d_block",    32'(blk0), 32'd0);
        check("d_sticky",   32'(stk0), 32'd0);
        check("d_count",    32'(cnt0), 32'd0);
        check("d_vec",      32'(vec0), 32'd0);
        tick(3);
        check("d_count3",   32'(cnt0), 32'd3);
        check("d_block3",   32'(blk0), 32'd0);
        tick(1);
        check("d_block4",   32'(blk0), 32'd1);
        check("d_sticky4",  32'(stk0), 32'd1);
        check("d_vec4",     32'(vec0), 32'(SNAP_EXP));

        // asynchronous reset while blocked, then restart from scratch
        reset = 1'b0;
        #1;
        check("r_block",    32'(blk0), 32'd0);
        check("r_sticky",   32'(stk0), 32'd0);
        check("r_count",    32'(cnt0), 32'd0);
        check("r_vec",      32'(vec0), 32'd0);
        #2;
        reset = 1'b1;
        tick(1);
        check("r_count1",   32'(cnt0), 32'd1);
        check("r_block1",   32'(blk0), 32'd0);
        tick(3);
        check("r_block4",   32'(blk0), 32'd1);

        // pure channel stall: only MODE 1 detects
        inst_idle_sigs  = 8'hFB;
        inst_block_sigs = 8'h04;
        axis_block_sigs = 2'b00;
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        check("e_m1_count0", 32'(cnt1), 32'd0);
        tick(3);
        check("e_m1_count3", 32'(cnt1), 32'd3);
        check("e_m1_block3", 32'(blk1), 32'd0);
        tick(1);
        check("e_m1_block4", 32'(blk1), 32'd1);
        check("e_m0_block",  32'(blk0), 32'd0);
        check("e_m0_count",  32'(cnt0), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
